// File: rtl/pipe_hazard_pkg.sv
// Shared constants for the issue-side hazard scoreboard.
//   NUM_REGS : architectural register count (x0 is never tracked)
//   REG_AW   : register index width
//   CNT_W    : per-register countdown width
//   MAX_LAT  : largest latency a producer may request; larger values clamp
//   LAT_*    : stall cycles a back-to-back consumer needs per producer class
//   clamp_lat: limits a requested latency to MAX_LAT
package pipe_hazard_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;
  localparam int CNT_W    = 3;
  localparam int MAX_LAT  = 7;

  localparam logic [CNT_W-1:0] LAT_ALU  = 3'd0;
  localparam logic [CNT_W-1:0] LAT_LOAD = 3'd1;
  localparam logic [CNT_W-1:0] LAT_MUL  = 3'd3;
  localparam logic [CNT_W-1:0] LAT_DIV  = 3'd7;

  function automatic logic [CNT_W-1:0] clamp_lat(input logic [CNT_W-1:0] lat);
    if (lat > CNT_W'(MAX_LAT)) return CNT_W'(MAX_LAT);
    return lat;
  endfunction

endpackage

// File: rtl/sb_reg_counter.sv
// One per-register countdown of cycles until the pending result is forwardable.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset, clears the count
//   load_i     : a new producer of this register issues this cycle
//   load_val_i : latency of that producer (already clamped)
//   cnt_o      : current remaining cycles
//   busy_o     : cnt_o != 0
// A load takes priority over the decrement; otherwise the count falls by one
// per cycle and rests at zero.
module sb_reg_counter
  import pipe_hazard_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             busy_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt_o  = cnt_q;
  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-side hazard unit: holds an instruction in ID while one of its sources
// (RAW) or its destination (WAW) belongs to an in-flight result that the
// bypass network cannot yet deliver.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   id_valid_i          : valid instruction in ID
//   id_rs1_i/id_rs2_i   : source registers, id_use_rs1_i/id_use_rs2_i qualify them
//   id_rd_i             : destination, id_reg_write_i qualifies it
//   id_lat_i            : stall cycles a back-to-back consumer of rd needs
//   flush_i             : kill the ID instruction this cycle
//   stall_o             : hold PC and IF/ID, bubble into ID/EXE
//   issue_o             : the ID instruction advances to EXE this cycle
//   busy_o              : bit r set while register r has a pending countdown
//   stall_cnt_o         : stalled-cycle count (only with SCOREBOARD_STATS_EN)
// Build option: define SCOREBOARD_STATS_EN to get a saturating stall counter;
// otherwise stall_cnt_o is constant zero.
// Handshake: id_valid_i is the producer's valid; ~stall_o acts as ready.
// An instruction transfers (issue_o) exactly when valid and not stalled and not
// flushed; while stalled, the ID inputs must be held and are re-evaluated each
// cycle. Outputs are combinational from current counters and ID inputs.
module hazard_scoreboard
  import pipe_hazard_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                id_valid_i,
  input  logic [REG_AW-1:0]   id_rs1_i,
  input  logic [REG_AW-1:0]   id_rs2_i,
  input  logic                id_use_rs1_i,
  input  logic                id_use_rs2_i,
  input  logic [REG_AW-1:0]   id_rd_i,
  input  logic                id_reg_write_i,
  input  logic [CNT_W-1:0]    id_lat_i,
  input  logic                flush_i,
  output logic                stall_o,
  output logic                issue_o,
  output logic [NUM_REGS-1:0] busy_o,
  output logic [31:0]         stall_cnt_o
);

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:1] load;
  logic [CNT_W-1:0]    lat_c;
  logic                raw;
  logic                waw;

  assign lat_c     = clamp_lat(id_lat_i);
  assign cnt[0]    = '0;
  assign busy_o[0] = 1'b0;

  // A zero-latency producer loads nothing: the WAW check already guarantees
  // its destination count is zero, so it simply stays there.
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    assign load[r] = issue_o && id_reg_write_i && (id_rd_i == REG_AW'(r)) &&
                     (lat_c != '0);
    sb_reg_counter u_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (load[r]),
      .load_val_i (lat_c),
      .cnt_o      (cnt[r]),
      .busy_o     (busy_o[r])
    );
  end

  // Checks use pre-issue counts, so rs == rd never makes an instruction wait
  // on itself.
  always_comb begin
    raw = id_valid_i &&
          ((id_use_rs1_i && (id_rs1_i != '0) && (cnt[id_rs1_i] != '0)) ||
           (id_use_rs2_i && (id_rs2_i != '0) && (cnt[id_rs2_i] != '0)));
    // An older result landing after ours would overwrite it; wait until the
    // older one is due no later than the new one.
    waw = id_valid_i && id_reg_write_i && (id_rd_i != '0) &&
          (cnt[id_rd_i] > lat_c);
  end

  assign stall_o = (raw || waw) && !flush_i && !rst_i;
  assign issue_o = id_valid_i && !stall_o && !flush_i && !rst_i;

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic        id_use_rs1_i, id_use_rs2_i, id_reg_write_i;
  logic [2:0]  id_lat_i;
  logic        flush_i;
  logic        stall_o, issue_o;
  logic [31:0] busy_o;
  logic [31:0] stall_cnt_o;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .id_valid_i     (id_valid_i),
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .id_use_rs1_i   (id_use_rs1_i),
    .id_use_rs2_i   (id_use_rs2_i),
    .id_rd_i        (id_rd_i),
    .id_reg_write_i (id_reg_write_i),
    .id_lat_i       (id_lat_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .issue_o        (issue_o),
    .busy_o         (busy_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  // ---------------- vectors ----------------
  typedef struct {
    logic        rst, valid;
    logic [4:0]  rs1, rs2;
    logic        u1, u2;
    logic [4:0]  rd;
    logic        rw;
    logic [2:0]  lat;
    logic        flush;
    logic        es, ei;
    logic [31:0] eb;
  } vec_t;

  function automatic vec_t mk(input logic rst, valid, input logic [4:0] rs1, rs2,
                              input logic u1, u2, input logic [4:0] rd,
                              input logic rw, input logic [2:0] lat,
                              input logic flush, es, ei, input logic [31:0] eb);
    vec_t v;
    v.rst = rst; v.valid = valid; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.rd = rd; v.rw = rw; v.lat = lat; v.flush = flush;
    v.es = es; v.ei = ei; v.eb = eb;
    return v;
  endfunction

  function automatic logic [31:0] b(input int r);
    return 32'd1 << r;
  endfunction

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_fail = 0;

  // Reference: remaining cycles before each register's result is forwardable.
  int     m_cnt [32];
  longint m_stat;

  task automatic chk(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h want %h", name, idx, got, want);
    end
  endtask

  // Drive one ID cycle, compare outputs (against the table when use_tbl,
  // else against the reference), then advance the reference past the edge.
  task automatic apply(input vec_t v, input bit use_tbl, input string name,
                       input int idx);
    bit          m_raw, m_waw, m_stall, m_issue;
    logic [31:0] m_busy, exp_stat;
    int          lat;
    @(negedge clk);
    rst_i = v.rst; id_valid_i = v.valid; id_rs1_i = v.rs1; id_rs2_i = v.rs2;
    id_use_rs1_i = v.u1; id_use_rs2_i = v.u2; id_rd_i = v.rd;
    id_reg_write_i = v.rw; id_lat_i = v.lat; flush_i = v.flush;
    #1;
    lat = (int'(v.lat) > 7) ? 7 : int'(v.lat);
    m_raw = v.valid && ((v.u1 && v.rs1 != 0 && m_cnt[v.rs1] > 0) ||
                        (v.u2 && v.rs2 != 0 && m_cnt[v.rs2] > 0));
    m_waw = v.valid && v.rw && v.rd != 0 && m_cnt[v.rd] > lat;
    m_stall = (m_raw || m_waw) && !v.flush && !v.rst;
    m_issue = v.valid && !m_stall && !v.flush && !v.rst;
    for (int r = 0; r < 32; r++) m_busy[r] = (m_cnt[r] > 0);
`ifdef SCOREBOARD_STATS_EN
    exp_stat = m_stat[31:0];
`else
    exp_stat = 32'd0;
`endif
    if (use_tbl) begin
      chk({name, "_stall"}, idx, {31'd0, stall_o}, {31'd0, v.es});
      chk({name, "_issue"}, idx, {31'd0, issue_o}, {31'd0, v.ei});
      chk({name, "_busy"},  idx, busy_o, v.eb);
    end else begin
      chk({name, "_stall"}, idx, {31'd0, stall_o}, {31'd0, m_stall});
      chk({name, "_issue"}, idx, {31'd0, issue_o}, {31'd0, m_issue});
      chk({name, "_busy"},  idx, busy_o, m_busy);
    end
    chk({name, "_stall_cnt"}, idx, stall_cnt_o, exp_stat);
    if (v.rst) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      m_stat = 0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (m_issue && v.rw && v.rd == r && lat != 0) m_cnt[r] = lat;
        else if (m_cnt[r] > 0) m_cnt[r] = m_cnt[r] - 1;
      end
      if (m_stall && m_stat < 64'hFFFF_FFFF) m_stat++;
    end
  endtask

  // ---------------- test ----------------
  vec_t tbl[$];
  vec_t rv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed table: each entry is one cycle, state carries forward.
    tbl.push_back(mk(0,1, 0,0,0,0, 5,1,1,0, 0,1, 0));      // LW x5
    tbl.push_back(mk(0,1, 5,1,1,1, 6,1,0,0, 1,0, b(5)));   // ADD x6,x5,x1 stalls
    tbl.push_back(mk(0,1, 5,1,1,1, 6,1,0,0, 0,1, 0));      // then issues
    tbl.push_back(mk(0,1, 1,2,1,1, 3,1,0,0, 0,1, 0));      // ADD x3
    tbl.push_back(mk(0,1, 3,1,1,1, 4,1,0,0, 0,1, 0));      // SUB uses x3, no stall
    tbl.push_back(mk(1,1, 3,1,1,1, 4,1,0,0, 0,0, 0));      // reset
    tbl.push_back(mk(0,1, 1,2,1,1, 7,1,3,0, 0,1, 0));      // MUL x7
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0,1, 7,0,1,0, 8,1,0,0, 1,0, b(7)));
    tbl.push_back(mk(0,1, 7,0,1,0, 8,1,0,0, 0,1, 0));
    tbl.push_back(mk(0,1, 1,2,1,1, 9,1,3,0, 0,1, 0));      // MUL x9
    for (int k = 0; k < 3; k++)                            // WAW ADD x9
      tbl.push_back(mk(0,1, 9,9,0,0, 9,1,0,0, 1,0, b(9)));
    tbl.push_back(mk(0,1, 9,9,0,0, 9,1,0,0, 0,1, 0));
    tbl.push_back(mk(0,0, 0,0,0,0, 0,0,0,0, 0,0, 0));      // cnt[9] back at 0
    tbl.push_back(mk(0,1, 1,2,1,1, 0,1,1,0, 0,1, 0));      // LW x0
    tbl.push_back(mk(0,1, 0,0,1,1, 14,1,0,0, 0,1, 0));     // use x0
    tbl.push_back(mk(0,1, 1,2,1,1, 10,1,3,0, 0,1, 0));     // MUL x10
    tbl.push_back(mk(0,1, 10,0,1,0, 11,1,3,1, 0,0, b(10))); // flushed consumer
    tbl.push_back(mk(0,1, 10,0,1,0, 11,1,3,0, 1,0, b(10))); // stalls
    tbl.push_back(mk(0,0, 0,0,0,0, 0,0,0,0, 0,0, b(10)));
    tbl.push_back(mk(0,0, 0,0,0,0, 0,0,0,0, 0,0, 0));      // x11 never loaded
    tbl.push_back(mk(0,1, 1,2,1,1, 4,1,3,0, 0,1, 0));      // MUL x4
    tbl.push_back(mk(0,0, 0,0,0,0, 0,0,0,0, 0,0, b(4)));   // cnt[4]=2 after
    tbl.push_back(mk(1,1, 4,0,1,0, 12,1,0,0, 0,0, b(4)));  // reset mid-MUL
    tbl.push_back(mk(0,1, 4,0,1,0, 12,1,0,0, 0,1, 0));     // issues, no stall
    tbl.push_back(mk(0,0, 0,0,0,0, 0,0,0,0, 0,0, 0));

    // Initial reset, not compared.
    rst_i = 1'b1; id_valid_i = 1'b0; id_rs1_i = '0; id_rs2_i = '0;
    id_use_rs1_i = 1'b0; id_use_rs2_i = 1'b0; id_rd_i = '0;
    id_reg_write_i = 1'b0; id_lat_i = '0; flush_i = 1'b0;
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_stat = 0;
    repeat (2) @(posedge clk);

    foreach (tbl[i]) apply(tbl[i], 1'b1, "tbl", i);

    // Longest latency: exactly 7 stall cycles before the consumer issues.
    apply(mk(0,1, 1,2,1,1, 13,1,7,0, 0,1, 0), 1'b1, "clamp_prod", 0);
    for (int k = 0; k <= 7; k++)
      apply(mk(0,1, 2,13,0,1, 15,1,0,0, (k < 7), (k == 7),
               (k < 7) ? b(13) : 32'd0), 1'b1, "clamp_cons", k);

    // Randomized traffic against the reference.
    apply(mk(1,0, 0,0,0,0, 0,0,0,0, 0,0, 0), 1'b0, "rnd_rst", 0);
    for (int i = 0; i < 600; i++) begin
      rv.rst   = ($urandom_range(0, 59) == 0);
      rv.valid = ($urandom_range(0, 9) != 0);
      rv.rs1   = 5'($urandom_range(0, 7));
      rv.rs2   = 5'($urandom_range(0, 7));
      rv.u1    = 1'($urandom_range(0, 1));
      rv.u2    = 1'($urandom_range(0, 1));
      rv.rd    = 5'($urandom_range(0, 7));
      rv.rw    = ($urandom_range(0, 3) != 0);
      rv.lat   = 3'($urandom_range(0, 7));
      rv.flush = ($urandom_range(0, 11) == 0);
      rv.es = 1'b0; rv.ei = 1'b0; rv.eb = '0;
      apply(rv, 1'b0, "rnd", i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
